// File: rtl/osd_spi_ctrl.sv
`default_nettype none
// ============================================================================
// osd_spi_ctrl : SPI master that arbitrates enable and line-write requests
//                and frames each one as an SS3-selected OSD command transfer.
// Revision     : 1.0
// ============================================================================
module osd_spi_ctrl #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        en_req,
    input  logic        en_val,
    output logic        en_ack,
    input  logic        wr_req,
    input  logic [3:0]  wr_line,
    output logic        wr_ack,
    output logic        rd_en,
    output logic [11:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        busy,
    output logic        SPI_SCK,
    output logic        SPI_SS3,
    output logic        SPI_DI
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_TAIL  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam logic [7:0] DIV_LAST      = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST      = 8'(GAP_CYCLES - 1);
    localparam logic       KIND_ENABLE   = 1'b0;
    localparam logic       KIND_WRITE    = 1'b1;
    localparam logic [8:0] LAST_BYTE_IDX = 9'd256;

    logic [1:0]  state;
    logic [1:0]  state_nx;

    logic [7:0]  cnt;
    logic        phase;
    logic [2:0]  bit_cnt;
    logic [8:0]  byte_idx;
    logic        kind;
    logic [3:0]  line;
    logic [7:0]  shifter;
    logic [7:0]  hold;
    logic        cap;

    logic        half_end;
    logic        byte_end;
    logic        last_byte;
    logic        accept_en;
    logic        accept_wr;

    logic        sck_nx;
    logic        ss3_nx;
    logic        di_nx;
    logic        rd_en_nx;
    logic [11:0] rd_addr_nx;
    logic        busy_nx;

    logic        sck_reg;
    logic        ss3_reg;
    logic        di_reg;
    logic        rd_en_reg;
    logic [11:0] rd_addr_reg;
    logic        busy_reg;
    logic        en_ack_reg;
    logic        wr_ack_reg;

    assign half_end  = (cnt == DIV_LAST);
    assign byte_end  = half_end & phase & (bit_cnt == 3'd7);
    assign last_byte = (kind == KIND_ENABLE) | (byte_idx == LAST_BYTE_IDX);
    assign accept_en = (state == ST_IDLE) & en_req;
    assign accept_wr = (state == ST_IDLE) & ~en_req & wr_req;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (en_req | wr_req)        state_nx = ST_SHIFT;
            ST_SHIFT: if (byte_end & last_byte)   state_nx = ST_TAIL;
            ST_TAIL:  if (half_end)               state_nx = ST_GAP;
            ST_GAP:   if (cnt == GAP_LAST)        state_nx = ST_IDLE;
            default:                              state_nx = ST_IDLE;
        endcase
    end

    // Bit timing, byte sequencing and the one-deep fetch buffer.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            phase    <= 1'b0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            kind     <= KIND_ENABLE;
            line     <= '0;
            shifter  <= '0;
            hold     <= '0;
            cap      <= 1'b0;
        end else begin
            cap <= rd_en_reg;
            if (cap) begin
                hold <= rd_data;
            end
            case (state)
                ST_IDLE: begin
                    cnt      <= '0;
                    phase    <= 1'b0;
                    bit_cnt  <= '0;
                    byte_idx <= '0;
                    if (accept_en) begin
                        kind    <= KIND_ENABLE;
                        shifter <= 8'h40 | {7'b0, en_val};
                    end else if (accept_wr) begin
                        kind    <= KIND_WRITE;
                        line    <= wr_line;
                        shifter <= {4'b0010, wr_line};
                    end
                end
                ST_SHIFT: begin
                    if (half_end) begin
                        cnt   <= '0;
                        phase <= ~phase;
                        if (phase) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (!last_byte) begin
                                    byte_idx <= byte_idx + 9'd1;
                                    shifter  <= hold;
                                end
                            end else begin
                                shifter <= {shifter[6:0], 1'b0};
                            end
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_TAIL: begin
                    cnt <= half_end ? '0 : cnt + 8'd1;
                end
                default: begin
                    cnt <= cnt + 8'd1;
                end
            endcase
        end
    end

    // Fetch for data byte k is issued on the first cycle of the byte before it.
    always_comb begin
        sck_nx     = (state == ST_SHIFT) & phase;
        ss3_nx     = ~((state == ST_SHIFT) | (state == ST_TAIL));
        di_nx      = (state == ST_SHIFT) & shifter[7];
        rd_en_nx   = (state == ST_SHIFT) & (kind == KIND_WRITE) & ~phase &
                     (cnt == 8'd0) & (bit_cnt == 3'd0) & ~byte_idx[8];
        rd_addr_nx = rd_en_nx ? {line, byte_idx[7:0]} : rd_addr_reg;
        busy_nx    = (state != ST_IDLE) | accept_en | accept_wr;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sck_reg     <= 1'b0;
            ss3_reg     <= 1'b1;
            di_reg      <= 1'b0;
            rd_en_reg   <= 1'b0;
            rd_addr_reg <= '0;
            busy_reg    <= 1'b0;
            en_ack_reg  <= 1'b0;
            wr_ack_reg  <= 1'b0;
        end else begin
            sck_reg     <= sck_nx;
            ss3_reg     <= ss3_nx;
            di_reg      <= di_nx;
            rd_en_reg   <= rd_en_nx;
            rd_addr_reg <= rd_addr_nx;
            busy_reg    <= busy_nx;
            en_ack_reg  <= accept_en;
            wr_ack_reg  <= accept_wr;
        end
    end

    assign SPI_SCK = sck_reg;
    assign SPI_SS3 = ss3_reg;
    assign SPI_DI  = di_reg;
    assign rd_en   = rd_en_reg;
    assign rd_addr = rd_addr_reg;
    assign busy    = busy_reg;
    assign en_ack  = en_ack_reg;
    assign wr_ack  = wr_ack_reg;

endmodule
`default_nettype wire

// File: tb/tb_osd_spi_ctrl.sv
`default_nettype none
// ============================================================================
// tb_osd_spi_ctrl : directed bench for osd_spi_ctrl with CLK_DIV=2 (a) and
//                   CLK_DIV=1 (b) instances sharing clock and reset.
// Revision        : 1.0
// ============================================================================
module tb_osd_spi_ctrl;

    localparam int GAP = 8;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    logic        a_en_req, a_en_val, a_wr_req, a_en_ack, a_wr_ack, a_rd_en;
    logic        a_busy, a_sck, a_ss3, a_di;
    logic [3:0]  a_wr_line;
    logic [7:0]  a_rd_data;
    logic [11:0] a_rd_addr;

    logic        b_en_req, b_en_val, b_wr_req, b_en_ack, b_wr_ack, b_rd_en;
    logic        b_busy, b_sck, b_ss3, b_di;
    logic [3:0]  b_wr_line;
    logic [7:0]  b_rd_data;
    logic [11:0] b_rd_addr;

    osd_spi_ctrl #(.CLK_DIV(2), .GAP_CYCLES(GAP)) u_dut_a (
        .clk_sys(clk_sys), .reset(reset),
        .en_req(a_en_req), .en_val(a_en_val), .en_ack(a_en_ack),
        .wr_req(a_wr_req), .wr_line(a_wr_line), .wr_ack(a_wr_ack),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .busy(a_busy), .SPI_SCK(a_sck), .SPI_SS3(a_ss3), .SPI_DI(a_di)
    );

    osd_spi_ctrl #(.CLK_DIV(1), .GAP_CYCLES(GAP)) u_dut_b (
        .clk_sys(clk_sys), .reset(reset),
        .en_req(b_en_req), .en_val(b_en_val), .en_ack(b_en_ack),
        .wr_req(b_wr_req), .wr_line(b_wr_line), .wr_ack(b_wr_ack),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .busy(b_busy), .SPI_SCK(b_sck), .SPI_SS3(b_ss3), .SPI_DI(b_di)
    );

    logic [7:0] mem [4096];
    int total = 0;
    int bad   = 0;

    logic        a_bits[$];
    logic [11:0] a_addrs[$];
    int          a_low = 0;
    logic        a_prev = 1'b0;
    logic        b_bits[$];
    logic [11:0] b_addrs[$];
    int          b_low = 0;
    logic        b_prev = 1'b0;

    // Byte store: data is valid only in the single cycle after rd_en.
    always @(posedge clk_sys) begin
        a_rd_data <= a_rd_en ? mem[a_rd_addr] : 8'hC3;
        b_rd_data <= b_rd_en ? mem[b_rd_addr] : 8'hC3;
    end

    always @(negedge clk_sys) begin
        if (a_sck && !a_prev && !a_ss3) a_bits.push_back(a_di);
        if (a_rd_en) a_addrs.push_back(a_rd_addr);
        if (!a_ss3) a_low++;
        a_prev = a_sck;
        if (b_sck && !b_prev && !b_ss3) b_bits.push_back(b_di);
        if (b_rd_en) b_addrs.push_back(b_rd_addr);
        if (!b_ss3) b_low++;
        b_prev = b_sck;
    end

    function automatic logic [7:0] exp_byte(input logic [3:0] line, input logic [7:0] k);
        return k ^ 8'hA5 ^ {line, 4'h0} ^ 8'h50;
    endfunction

    function automatic logic [7:0] get_byte(input bit s, input int idx);
        logic [7:0] v;
        v = 8'h00;
        for (int j = 0; j < 8; j++) v = {v[6:0], s ? b_bits[idx*8+j] : a_bits[idx*8+j]};
        return v;
    endfunction

    function automatic logic wr_ack_of(input bit s); return s ? b_wr_ack : a_wr_ack; endfunction
    function automatic logic busy_of(input bit s);   return s ? b_busy : a_busy;     endfunction
    function automatic int   low_of(input bit s);    return s ? b_low : a_low;       endfunction
    function automatic int   nbits_of(input bit s);  return s ? b_bits.size() : a_bits.size();   endfunction
    function automatic int   naddr_of(input bit s);  return s ? b_addrs.size() : a_addrs.size(); endfunction
    function automatic logic [11:0] addr_at(input bit s, input int i);
        return s ? b_addrs[i] : a_addrs[i];
    endfunction

    task automatic set_wr(input bit s, input logic req, input logic [3:0] line);
        if (s) begin b_wr_req = req; b_wr_line = line; end
        else   begin a_wr_req = req; a_wr_line = line; end
    endtask

    task automatic clear_mon();
        @(posedge clk_sys);
        a_bits.delete(); a_addrs.delete(); a_low = 0;
        b_bits.delete(); b_addrs.delete(); b_low = 0;
    endtask

    // Full line write on one instance: command, 256 data bytes, fetch order, timing.
    task automatic run_write(input bit s, input logic [3:0] line, input string name);
        int d, t, errs, first;
        logic [7:0] got;
        d = s ? 1 : 2;
        clear_mon();
        @(negedge clk_sys);
        set_wr(s, 1'b1, line);
        t = 0;
        do begin @(negedge clk_sys); t++; end while (!wr_ack_of(s) && t < 10);
        total++;
        if (t !== 1) begin bad++; $display("FAIL %s_ack_latency: got %0d want 1", name, t); end
        set_wr(s, 1'b0, line);
        t = 0;
        while (busy_of(s) && t < 20000) begin @(negedge clk_sys); t++; end
        total++;
        if (t !== 1 + 4112*d + d + GAP) begin
            bad++; $display("FAIL %s_busy_len: got %0d want %0d", name, t, 1 + 4112*d + d + GAP);
        end
        total++;
        if (low_of(s) !== 4112*d + d) begin
            bad++; $display("FAIL %s_ss3_low: got %0d want %0d", name, low_of(s), 4112*d + d);
        end
        total++;
        if (nbits_of(s) !== 2056) begin
            bad++; $display("FAIL %s_sck_edges: got %0d want 2056", name, nbits_of(s));
        end else begin
            total++;
            got = get_byte(s, 0);
            if (got !== {4'b0010, line}) begin
                bad++; $display("FAIL %s_cmd: got %h want %h", name, got, {4'b0010, line});
            end
            errs = 0; first = -1;
            for (int k = 0; k < 256; k++) begin
                if (get_byte(s, k + 1) !== exp_byte(line, 8'(k))) begin
                    errs++;
                    if (first < 0) first = k;
                end
            end
            total++;
            if (errs != 0) begin
                bad++; $display("FAIL %s_data: %0d bad bytes, first k=%0d got %h want %h", name, errs,
                                first, get_byte(s, first + 1), exp_byte(line, 8'(first)));
            end
        end
        total++;
        if (naddr_of(s) !== 256) begin
            bad++; $display("FAIL %s_rd_count: got %0d want 256", name, naddr_of(s));
        end else begin
            errs = 0; first = -1;
            for (int k = 0; k < 256; k++) begin
                if (addr_at(s, k) !== {line, 8'(k)}) begin
                    errs++;
                    if (first < 0) first = k;
                end
            end
            total++;
            if (errs != 0) begin
                bad++; $display("FAIL %s_rd_addr: k=%0d got %h want %h", name, first,
                                addr_at(s, first), {line, 8'(first)});
            end
        end
    endtask

    task automatic test_reset();
        logic [18:0] va, vb;
        repeat (3) @(negedge clk_sys);
        va = {a_ss3, a_sck, a_di, a_en_ack, a_wr_ack, a_rd_en, a_busy, a_rd_addr};
        vb = {b_ss3, b_sck, b_di, b_en_ack, b_wr_ack, b_rd_en, b_busy, b_rd_addr};
        total++;
        if (va !== {1'b1, 18'h0}) begin bad++; $display("FAIL reset_a: got %h want %h", va, {1'b1, 18'h0}); end
        total++;
        if (vb !== {1'b1, 18'h0}) begin bad++; $display("FAIL reset_b: got %h want %h", vb, {1'b1, 18'h0}); end
        reset = 1'b0;
        repeat (3) @(negedge clk_sys);
        va = {a_ss3, a_sck, a_di, a_en_ack, a_wr_ack, a_rd_en, a_busy, a_rd_addr};
        total++;
        if (va !== {1'b1, 18'h0}) begin bad++; $display("FAIL idle_after_reset: got %h want %h", va, {1'b1, 18'h0}); end
    endtask

    task automatic test_enable();
        int t;
        clear_mon();
        @(negedge clk_sys);
        a_en_val = 1'b1;
        a_en_req = 1'b1;
        t = 0;
        do begin @(negedge clk_sys); t++; end while (!a_en_ack && t < 10);
        total++;
        if (t !== 1) begin bad++; $display("FAIL enable_ack_latency: got %0d want 1", t); end
        a_en_req = 1'b0;
        @(negedge clk_sys);
        total++;
        if ({a_en_ack, a_ss3} !== 2'b00) begin
            bad++; $display("FAIL enable_ack_pulse_ss3: got %b want 00", {a_en_ack, a_ss3});
        end
        t = 1;
        while (a_busy && t < 200) begin @(negedge clk_sys); t++; end
        total++;
        if (t !== 43) begin bad++; $display("FAIL enable_busy_len: got %0d want 43", t); end
        total++;
        if (a_low !== 34) begin bad++; $display("FAIL enable_ss3_low: got %0d want 34", a_low); end
        total++;
        if (a_bits.size() !== 8) begin
            bad++; $display("FAIL enable_sck_edges: got %0d want 8", a_bits.size());
        end else begin
            total++;
            if (get_byte(1'b0, 0) !== 8'h41) begin
                bad++; $display("FAIL enable_cmd: got %h want 41", get_byte(1'b0, 0));
            end
        end
    endtask

    task automatic test_write();
        run_write(1'b0, 4'd5, "write");
    endtask

    task automatic test_priority();
        int t;
        clear_mon();
        @(negedge clk_sys);
        a_en_val = 1'b0;
        a_en_req = 1'b1;
        a_wr_req = 1'b1;
        a_wr_line = 4'd2;
        t = 0;
        do begin @(negedge clk_sys); t++; end while (!a_en_ack && !a_wr_ack && t < 10);
        total++;
        if ({a_en_ack, a_wr_ack} !== 2'b10) begin
            bad++; $display("FAIL prio_first_ack: got %b want 10", {a_en_ack, a_wr_ack});
        end
        a_en_req = 1'b0;
        t = 0;
        while (!a_wr_ack && t < 200) begin @(negedge clk_sys); t++; end
        total++;
        if (t !== 43) begin bad++; $display("FAIL prio_wr_ack_delay: got %0d want 43", t); end
        a_wr_req = 1'b0;
        t = 0;
        while (a_busy && t < 20000) begin @(negedge clk_sys); t++; end
        total++;
        if (a_bits.size() !== 8 + 2056) begin
            bad++; $display("FAIL prio_sck_edges: got %0d want %0d", a_bits.size(), 8 + 2056);
        end else begin
            total++;
            if ({get_byte(1'b0, 0), get_byte(1'b0, 1), get_byte(1'b0, 2), get_byte(1'b0, 257)} !==
                {8'h40, 8'h22, exp_byte(4'd2, 8'h00), exp_byte(4'd2, 8'hFF)}) begin
                bad++; $display("FAIL prio_frames: got %h %h %h %h want 40 22 %h %h", get_byte(1'b0, 0),
                                get_byte(1'b0, 1), get_byte(1'b0, 2), get_byte(1'b0, 257),
                                exp_byte(4'd2, 8'h00), exp_byte(4'd2, 8'hFF));
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int t;
        clear_mon();
        @(negedge clk_sys);
        set_wr(1'b0, 1'b1, 4'd3);
        t = 0;
        do begin @(negedge clk_sys); t++; end while (!a_wr_ack && t < 10);
        set_wr(1'b0, 1'b0, 4'd3);
        t = 0;
        while (a_addrs.size() < 101 && t < 20000) begin @(negedge clk_sys); t++; end
        total++;
        if (a_addrs.size() < 101) begin
            bad++; $display("FAIL midrst_reach_byte100: got %0d want 101", a_addrs.size());
        end
        reset = 1'b1;
        #1;
        total++;
        if ({a_ss3, a_sck, a_busy, a_rd_en} !== 4'b1000) begin
            bad++; $display("FAIL midrst_async: got %b want 1000", {a_ss3, a_sck, a_busy, a_rd_en});
        end
        @(negedge clk_sys);
        reset = 1'b0;
        repeat (3) @(negedge clk_sys);
        total++;
        if ({a_ss3, a_busy} !== 2'b10) begin
            bad++; $display("FAIL midrst_idle: got %b want 10", {a_ss3, a_busy});
        end
        run_write(1'b0, 4'd3, "restart");
    endtask

    task automatic test_held();
        int acks[$];
        int runs[$];
        int hi_run, t, errs;
        logic seen_low;
        hi_run = 0; seen_low = 1'b0;
        clear_mon();
        @(negedge clk_sys);
        b_en_val = 1'b1;
        b_en_req = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_sys);
            if (b_en_ack) acks.push_back(c);
            if (b_ss3) hi_run++;
            else begin
                if (hi_run > 0 && seen_low) runs.push_back(hi_run);
                hi_run = 0;
                seen_low = 1'b1;
            end
        end
        b_en_req = 1'b0;
        t = 0;
        while (b_busy && t < 1000) begin @(negedge clk_sys); t++; end
        total++;
        if (acks.size() !== 8) begin bad++; $display("FAIL held_ack_count: got %0d want 8", acks.size()); end
        errs = 0;
        for (int i = 1; i < acks.size(); i++) if (acks[i] - acks[i-1] != 26) errs++;
        total++;
        if (errs != 0) begin bad++; $display("FAIL held_ack_period: %0d gaps differ from 26", errs); end
        // Between frames SS3 stays high for the gap plus the next acceptance cycle.
        errs = 0;
        for (int i = 0; i < runs.size(); i++) if (runs[i] != GAP + 1) errs++;
        total++;
        if (runs.size() !== 7 || errs != 0) begin
            bad++; $display("FAIL held_ss3_gap: runs=%0d bad=%0d want 7 runs of %0d", runs.size(), errs, GAP + 1);
        end
        errs = 0;
        for (int i = 0; i < 8; i++) if (get_byte(1'b1, i) !== 8'h41) errs++;
        total++;
        if (b_bits.size() !== 64 || errs != 0) begin
            bad++; $display("FAIL held_frames: bits=%0d bad_bytes=%0d want 64 bits of 41", b_bits.size(), errs);
        end
    endtask

    task automatic test_stress();
        run_write(1'b1, 4'd9, "stress");
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = exp_byte(4'(i >> 8), 8'(i));
        a_en_req = 1'b0; a_en_val = 1'b0; a_wr_req = 1'b0; a_wr_line = 4'd0;
        b_en_req = 1'b0; b_en_val = 1'b0; b_wr_req = 1'b0; b_wr_line = 4'd0;
        test_reset();
        test_enable();
        test_write();
        test_priority();
        test_reset_mid_write();
        test_held();
        test_stress();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
